// File: rtl/register_file.sv
// 32 x WIDTH general-purpose register file: two combinational read ports, one
// clocked write port, R[0] hardwired to zero, asynchronous active-high clear.
module register_file #(
    parameter int WIDTH = 32,
    parameter int ADDR  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWr,
    input  logic [ADDR-1:0]  Rw,
    input  logic [ADDR-1:0]  Ra,
    input  logic [ADDR-1:0]  Rb,
    input  logic [WIDTH-1:0] busW,
    output logic [WIDTH-1:0] busA,
    output logic [WIDTH-1:0] busB
);

    localparam int DEPTH = 2 ** ADDR;

    // R[0] has no storage element; only R[1..DEPTH-1] exist as flops.
    logic [WIDTH-1:0] regs [1:DEPTH-1];

    // NOTE: every register is cleared by reset, so this array is built from
    // flops rather than RAM macros, and the state register uses <= only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (RegWr && (Rw != '0)) begin
            regs[Rw] <= busW;
        end
    end

    // Reads see stored state only; a busW bypass would close a loop through the ALU.
    always_comb begin
        busA = '0;
        busB = '0;
        if (Ra != '0) busA = regs[Ra];
        if (Rb != '0) busB = regs[Rb];
    end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: reset, write/read, R0
// protection, write disable, read-during-write, dual port and mid-cycle reset.
module tb_register_file;

    localparam int WIDTH = 32;
    localparam int ADDR  = 5;

    logic             clk;
    logic             reset;
    logic             RegWr;
    logic [ADDR-1:0]  Rw;
    logic [ADDR-1:0]  Ra;
    logic [ADDR-1:0]  Rb;
    logic [WIDTH-1:0] busW;
    logic [WIDTH-1:0] busA;
    logic [WIDTH-1:0] busB;

    int total = 0;
    int bad   = 0;

    register_file #(.WIDTH(WIDTH), .ADDR(ADDR)) dut (
        .clk   (clk),
        .reset (reset),
        .RegWr (RegWr),
        .Rw    (Rw),
        .Ra    (Ra),
        .Rb    (Rb),
        .busW  (busW),
        .busA  (busA),
        .busB  (busB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write one register, then drop RegWr; leaves time at edge + 1.
    task automatic writeReg(input logic [ADDR-1:0] addr, input logic [WIDTH-1:0] data);
        RegWr = 1'b1;
        Rw    = addr;
        busW  = data;
        tick();
        RegWr = 1'b0;
    endtask

    task automatic test_reset();
        writeReg(5'd5, 32'h11111111);
        writeReg(5'd31, 32'h22222222);
        Ra = 5'd5;
        Rb = 5'd31;
        #1;
        total++;
        if (busA !== 32'h11111111) begin
            bad++;
            $display("FAIL reset_prewrite_a got=%h want=%h", busA, 32'h11111111);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (busA !== '0) begin
            bad++;
            $display("FAIL reset_async_a got=%h want=%h", busA, 32'h0);
        end
        total++;
        if (busB !== '0) begin
            bad++;
            $display("FAIL reset_async_b got=%h want=%h", busB, 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        for (int i = 0; i < 32; i++) begin
            Ra = ADDR'(i);
            Rb = ADDR'(31 - i);
            #1;
            total++;
            if (busA !== '0) begin
                bad++;
                $display("FAIL reset_clear_r%0d got=%h want=%h", i, busA, 32'h0);
            end
        end
    endtask

    task automatic test_basic_write();
        writeReg(5'd8, 32'hDEADBEEF);
        Ra = 5'd8;
        #1;
        total++;
        if (busA !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL basic_r8 got=%h want=%h", busA, 32'hDEADBEEF);
        end
        writeReg(5'd9, 32'h00000001);
        Rb = 5'd9;
        #1;
        total++;
        if (busB !== 32'h00000001) begin
            bad++;
            $display("FAIL basic_r9_slt got=%h want=%h", busB, 32'h00000001);
        end
    endtask

    task automatic test_r0();
        writeReg(5'd0, 32'hFFFFFFFF);
        Ra = 5'd0;
        Rb = 5'd0;
        #1;
        total++;
        if (busA !== '0) begin
            bad++;
            $display("FAIL r0_a got=%h want=%h", busA, 32'h0);
        end
        total++;
        if (busB !== '0) begin
            bad++;
            $display("FAIL r0_b got=%h want=%h", busB, 32'h0);
        end
        // Registers untouched by the R0 write must still hold.
        Ra = 5'd8;
        #1;
        total++;
        if (busA !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL r0_side_effect got=%h want=%h", busA, 32'hDEADBEEF);
        end
    endtask

    task automatic test_hold_and_rdw();
        writeReg(5'd3, 32'h12345678);
        Ra    = 5'd3;
        RegWr = 1'b0;
        Rw    = 5'd3;
        busW  = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (busA !== 32'h12345678) begin
                bad++;
                $display("FAIL hold_r3_edge%0d got=%h want=%h", i, busA, 32'h12345678);
            end
        end
        RegWr = 1'b1;
        busW  = 32'hCAFEF00D;
        #2;
        total++;
        if (busA !== 32'h12345678) begin
            bad++;
            $display("FAIL rdw_before_edge got=%h want=%h", busA, 32'h12345678);
        end
        tick();
        RegWr = 1'b0;
        total++;
        if (busA !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL rdw_after_edge got=%h want=%h", busA, 32'hCAFEF00D);
        end
    endtask

    task automatic test_dual_port();
        writeReg(5'd17, 32'h80000000);
        writeReg(5'd18, 32'h7FFFFFFF);
        Ra = 5'd17;
        Rb = 5'd17;
        #1;
        total++;
        if (busA !== 32'h80000000) begin
            bad++;
            $display("FAIL dual_same_a got=%h want=%h", busA, 32'h80000000);
        end
        total++;
        if (busB !== 32'h80000000) begin
            bad++;
            $display("FAIL dual_same_b got=%h want=%h", busB, 32'h80000000);
        end
        Rb = 5'd18;
        #1;
        total++;
        if (busA !== 32'h80000000) begin
            bad++;
            $display("FAIL dual_diff_a got=%h want=%h", busA, 32'h80000000);
        end
        total++;
        if (busB !== 32'h7FFFFFFF) begin
            bad++;
            $display("FAIL dual_diff_b got=%h want=%h", busB, 32'h7FFFFFFF);
        end
    endtask

    task automatic test_reset_mid_write();
        writeReg(5'd20, 32'hA5A5A5A5);
        Ra = 5'd20;
        #1;
        total++;
        if (busA !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL mid_prewrite got=%h want=%h", busA, 32'hA5A5A5A5);
        end
        RegWr = 1'b1;
        Rw    = 5'd20;
        busW  = 32'h5A5A5A5A;
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (busA !== '0) begin
            bad++;
            $display("FAIL mid_reset_async got=%h want=%h", busA, 32'h0);
        end
        tick();
        total++;
        if (busA !== '0) begin
            bad++;
            $display("FAIL mid_reset_held_edge got=%h want=%h", busA, 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        RegWr = 1'b0;
        tick();
        total++;
        if (busA !== '0) begin
            bad++;
            $display("FAIL mid_after_release got=%h want=%h", busA, 32'h0);
        end
        writeReg(5'd20, 32'h13579BDF);
        total++;
        if (busA !== 32'h13579BDF) begin
            bad++;
            $display("FAIL mid_rewrite got=%h want=%h", busA, 32'h13579BDF);
        end
    endtask

    initial begin
        reset = 1'b1;
        RegWr = 1'b0;
        Rw    = '0;
        Ra    = 5'd7;
        Rb    = 5'd12;
        busW  = '0;
        #2;
        total++;
        if (busA !== '0 || busB !== '0) begin
            bad++;
            $display("FAIL initial_reset got=%h/%h want=0/0", busA, busB);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();

        test_reset();
        test_basic_write();
        test_r0();
        test_hold_and_rdw();
        test_dual_port();
        test_reset_mid_write();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
